mips_multicycle_core: RTL

Parametrised multi-cycle successor to the single-cycle MIPS top level. It runs a fetch/decode/execute/writeback state machine against an external instruction memory that uses a req/valid handshake, so wait states are tolerated. It extends the ISA with addi, ori, shifts, and halt, and adds a retired-instruction counter and a debug register read port. It is the core instance under the SoC top, with imem and the bench as its only neighbours.

---
 rtl/mips_multicycle_core.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// ---------------------------------------------------------------------------
// mips_multicycle_core
//
// Multi-cycle MIPS-subset core. Each instruction walks through
// FETCH -> DECODE -> EXECUTE -> WRITEBACK, so it takes 4 cycles when the
// instruction memory answers at once. Every cycle the memory holds off
// imem_valid adds one cycle. Instructions never overlap. Opcode 0x3F parks
// the core in HALT, and only reset brings it out again.
//
// Supported instructions:
//   R-type (opcode 0x00): add, sub, and, or, sll, srl
//   addi (0x08), ori (0x0D), halt (0x3F)
//   Every other encoding retires as a nop.
//
// Parameters:
//   DATA_W   datapath / register width (must be >= 16)
//   ADDR_W   word-indexed instruction address width
//   RESET_PC PC value loaded on reset
//   CNT_W    width of the saturating retired-instruction counter
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   imem_req      fetch request; high in FETCH while out of reset
//   imem_addr     fetch address (the PC)
//   imem_valid    instruction word valid; completes the fetch handshake
//   imem_rdata    instruction word
//   dbg_reg_sel   debug register select
//   dbg_reg_data  combinational read of the selected register (r0 reads 0)
//   halted        core is in HALT
//   retired       saturating count of retired instructions
// ---------------------------------------------------------------------------
module mips_multicycle_core #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    input  logic [4:0]        dbg_reg_sel,
    output logic [DATA_W-1:0] dbg_reg_data,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic              wr_en_q;
    logic [4:0]        wr_dst_q;
    logic [DATA_W-1:0] regs [32];

    // Instruction fields, taken from the held instruction register.
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm16  = ir[15:0];

    // The size cast of a signed value sign-extends. This also stays legal
    // when DATA_W is 16, where a zero-count replication would not be.
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    assign imm_sext = DATA_W'($signed(imm16));
    assign imm_zext = DATA_W'(imm16);

    // shamt can reach 31. With a narrow datapath, any shift of the full
    // width or more must give zero.
    logic shamt_oob;
    assign shamt_oob = (int'(shamt) >= DATA_W);

    // ALU and destination select, evaluated during EXECUTE.
    logic [DATA_W-1:0] alu_y;
    logic              alu_we;
    logic [4:0]        alu_dst;

    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        alu_y   = '0;
        alu_we  = 1'b0;
        alu_dst = rd;
        case (opcode)
            OP_RTYPE: begin
                alu_we = 1'b1;
                case (funct)
                    FN_ADD:  alu_y = a_q + b_q;
                    FN_SUB:  alu_y = a_q - b_q;
                    FN_AND:  alu_y = a_q & b_q;
                    FN_OR:   alu_y = a_q | b_q;
                    FN_SLL:  alu_y = shamt_oob ? '0 : (b_q << shamt);
                    FN_SRL:  alu_y = shamt_oob ? '0 : (b_q >> shamt);
                    default: alu_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_we  = 1'b1;
                alu_dst = rt;
                alu_y   = a_q + imm_sext;
            end
            OP_ORI: begin
                alu_we  = 1'b1;
                alu_dst = rt;
                alu_y   = a_q | imm_zext;
            end
            default: ;
        endcase
    end

    // Main sequencer. All architectural state lives here.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_FETCH;
            pc       <= ADDR_W'(RESET_PC);
            ir       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            wr_en_q  <= 1'b0;
            wr_dst_q <= '0;
            retired  <= '0;
            halted   <= 1'b0;
            // NOTE: the register file has an architectural reset value of
            // zero, so it is cleared here rather than left as plain storage.
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= regs[rs];
                    b_q <= regs[rt];
                    if (opcode == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    result_q <= alu_y;
                    wr_en_q  <= alu_we;
                    wr_dst_q <= alu_dst;
                    state    <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    // r0 is hard-wired to zero, so writes to it are dropped.
                    if (wr_en_q && (wr_dst_q != 5'd0)) begin
                        regs[wr_dst_q] <= result_q;
                    end
                    pc <= pc + ADDR_W'(1);
                    if (retired != '1) begin
                        retired <= retired + CNT_W'(1);
                    end
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // The request is gated by reset directly, so it drops in the same cycle
    // reset is asserted rather than one edge later.
    assign imem_req  = (state == S_FETCH) && reset;
    assign imem_addr = pc;

    assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? '0 : regs[dbg_reg_sel];

endmodule
